scl_rx_controller: RTL
======================

SCL_RX_CONTROLLER -- requirements
Module: scl_rx_controller

Interface
REQ-001 Parameter: ACK_ENABLE, default 1, meaning: 1 = drive ACK low after each accepted byte, 0 = never drive SDA.
REQ-002 Port: clk, input, 1, system clock, all logic on its rising edge.
REQ-003 Port: rst, input, 1, synchronous active-high reset.
REQ-004 Port: scl, input, 1, asynchronous serial clock line.
REQ-005 Port: sda_in, input, 1, asynchronous serial data line.
REQ-006 Port: sda_out, output, 1, open-drain drive request: 0 = pull low, 1 = release.
REQ-007 Port: rx_data, output, 8, last received byte.
REQ-008 Port: rx_valid, output, 1, rx_data holds an unconsumed byte.
REQ-009 Port: rx_ready, input, 1, consumer accepts rx_data when rx_valid=1.
REQ-010 Port: busy, output, 1, high whenever the FSM is not in IDLE.
REQ-011 Port: overrun, output, 1, one-cycle pulse when a byte is dropped.

Function
REQ-012 The block SHALL pass scl and sda_in each through a 2-flop synchronizer, plus one history flop, all reset to 1.
REQ-013 scl_rise SHALL be sync_scl=1 with prev_scl=0, and scl_fall SHALL be sync_scl=0 with prev_scl=1.
REQ-014 start SHALL be sda 1->0 while sync_scl and prev_scl are both 1; stop SHALL be sda 0->1 under the same condition.
REQ-015 Line-to-detection latency SHALL be exactly 3 clk cycles.
REQ-016 The FSM SHALL have four states: IDLE, RX_BIT, ACK_SETUP, ACK_DRIVE.
REQ-017 IDLE: sda_out=1; on start go to RX_BIT with bit_cnt=0 and shift register=0.
REQ-018 RX_BIT: on scl_rise shift sync_sda into the LSB, MSB-first, and increment bit_cnt (4-bit).
REQ-019 RX_BIT: when the 8th scl_rise is taken, go to ACK_SETUP.
REQ-020 ACK_SETUP, on scl_fall, buffer free (rx_valid=0, or rx_valid&rx_ready this cycle): load rx_data; set rx_valid=1 next cycle; sda_out=~ACK_ENABLE; go to ACK_DRIVE.
REQ-021 ACK_SETUP, on scl_fall, buffer full: keep rx_data; pulse overrun for 1 cycle; sda_out=1 (NACK); go to ACK_DRIVE.
REQ-022 ACK_DRIVE: hold sda_out through the ACK high phase; on the next scl_fall set sda_out=1, bit_cnt=0, and go to RX_BIT.
REQ-023 start in any non-IDLE state (repeated start) SHALL force RX_BIT with bit_cnt=0, shift=0, sda_out=1.
REQ-024 stop in any state SHALL force IDLE with sda_out=1; a partial byte is discarded and overrun does not assert.
REQ-025 start/stop SHALL take priority over scl_rise/scl_fall in the same cycle.
REQ-026 rx_valid SHALL clear the cycle after rx_valid&rx_ready, unless a new byte loads that same cycle, in which case rx_valid stays 1 with the new data.
REQ-027 rx_data and rx_valid SHALL NOT be affected by stop or repeated start.
REQ-028 busy SHALL be combinational (state!=IDLE); sda_out, rx_data, rx_valid and overrun SHALL be registered.

Reset
REQ-029 When rst=1 at a clk edge: state=IDLE, bit_cnt=0, shift=0, rx_data=8'h00, rx_valid=0, overrun=0, sda_out=1, all synchronizer and history flops=1.
REQ-030 Reset mid-byte SHALL abandon the transfer; the block SHALL then wait for a fresh start.
REQ-031 rst SHALL override every other input in the same cycle.

Verification
REQ-032 Bench SHALL cover: start, byte 8'hA5, rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=8'hA5; sda_out=0 exactly for the 9th SCL period; overrun=0.
REQ-033 Bench SHALL cover: two bytes 8'h3C then 8'hC3, rx_ready=0 -> first byte ACKed and held; second byte NACKed (sda_out=1); overrun pulses once; rx_data stays 8'h3C.
REQ-034 Bench SHALL cover: stop after 5 bits -> IDLE, busy=0, rx_valid unchanged; next start plus 8'h01 -> rx_data=8'h01.
REQ-035 Bench SHALL cover: repeated start after 3 bits, then 8'hFF -> rx_data=8'hFF, no overrun.
REQ-036 Bench SHALL cover: ACK_ENABLE=0, byte 8'h55 -> sda_out stays 1 throughout; rx_data=8'h55.
REQ-037 Bench SHALL cover: rst asserted during ACK_DRIVE -> next cycle sda_out=1, busy=0, rx_valid=0.

Source files
------------

// File: rtl/scl_rx_controller.sv
// Receive-only serial-bus byte controller.
// Samples scl/sda through synchronizers, detects start/stop and clock
// edges, shifts in bytes MSB-first, and answers each byte with ACK or
// NACK depending on whether the single-entry output buffer had room.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | bus free, waiting for a start condition
// RX_BIT    | shifting in data bits on each scl rise
// ACK_SETUP | 8 bits in, waiting for scl fall to present ACK/NACK
// ACK_DRIVE | ACK/NACK on sda for the 9th clock, released on next fall
module scl_rx_controller #(
  parameter int unsigned ACK_ENABLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RX_BIT    = 2'd1,
    ACK_SETUP = 2'd2,
    ACK_DRIVE = 2'd3
  } state_t;

  logic       scl_s1_q, scl_s2_q, scl_prev_q;
  logic       sda_s1_q, sda_s2_q, sda_prev_q;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       sda_out_q, sda_out_d;

  logic       scl_rise, scl_fall, start_det, stop_det, buf_free;
  logic       ack_level;

  // Two-flop synchronizers plus one history flop per line; idle-high reset
  // keeps the detectors quiet after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign buf_free  = ~rx_valid_q | rx_ready;
  assign ack_level = (ACK_ENABLE == 0) ? 1'b1 : 1'b0;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      sda_out_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      sda_out_q  <= sda_out_d;
    end
  end

  // Next-state logic; bus conditions outrank clock edges, and the output
  // buffer drains independently of what the bus is doing.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    overrun_d  = 1'b0;
    sda_out_d  = sda_out_q;

    if (stop_det) begin
      state_d   = IDLE;
      sda_out_d = 1'b1;
    end else if (start_det) begin
      state_d   = RX_BIT;
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
      sda_out_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sda_out_d = 1'b1;
        end
        RX_BIT: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d = ACK_SETUP;
            end
          end
        end
        ACK_SETUP: begin
          if (scl_fall) begin
            if (buf_free) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_out_d  = ack_level;
            end else begin
              overrun_d = 1'b1;
              sda_out_d = 1'b1;
            end
            state_d = ACK_DRIVE;
          end
        end
        ACK_DRIVE: begin
          if (scl_fall) begin
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
            shift_d   = 8'h00;
            state_d   = RX_BIT;
          end
        end
        default: begin
          state_d   = IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign sda_out  = sda_out_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule
